// File: rtl/mips_pkg.sv
// Shared register-file writeback types and widths.
package mips_pkg;

   localparam int unsigned REG_W  = 5;
   localparam int unsigned DATA_W = 32;

   localparam logic [REG_W-1:0] REG_ZERO = '0;

   // One pending register-file write: destination register and value.
   typedef struct packed {
      logic [REG_W-1:0]  wreg;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// MDU result FIFO: DEPTH-entry circular buffer with occupancy count and a
// per-entry valid/register view for the hazard CAM.
// Optional macro MIPS_WB_FWD_EN exposes entry data and the read pointer.
module wb_fifo
   import mips_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  wb_entry_t                    push_ent,
   input  logic                         pop,
   output wb_entry_t                    head,
   output logic [$clog2(DEPTH):0]       cnt,
   output logic [DEPTH-1:0]             ent_vld,
   output logic [DEPTH-1:0][REG_W-1:0]  ent_reg
`ifdef MIPS_WB_FWD_EN
   ,
   output logic [DEPTH-1:0][DATA_W-1:0] ent_data,
   output logic [$clog2(DEPTH)-1:0]     rd_ptr
`endif
);

   localparam int unsigned PW = $clog2(DEPTH);

   wb_entry_t          mem_q [DEPTH];
   logic [DEPTH-1:0]   vld_q;
   logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [PW:0]        cnt_q, cnt_d;

   // Occupancy next state; push and pop together leave it unchanged.
   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop) cnt_d = cnt_q + 1'b1;
      else if (!push && pop) cnt_d = cnt_q - 1'b1;
   end

   // Storage, valid bits and pointers; pointers wrap naturally (DEPTH is 2^n).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         vld_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= push_ent;
            vld_q[wr_ptr_q] <= 1'b1;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            vld_q[rd_ptr_q] <= 1'b0;
            rd_ptr_q        <= rd_ptr_q + 1'b1;
         end
         cnt_q <= cnt_d;
      end
   end

   // Flatten the entry array for the compare logic in the arbiter.
   always_comb begin
      ent_reg = '0;
`ifdef MIPS_WB_FWD_EN
      ent_data = '0;
`endif
      for (int unsigned i = 0; i < DEPTH; i++) begin
         ent_reg[i] = mem_q[i].wreg;
`ifdef MIPS_WB_FWD_EN
         ent_data[i] = mem_q[i].data;
`endif
      end
   end

   assign head    = mem_q[rd_ptr_q];
   assign cnt     = cnt_q;
   assign ent_vld = vld_q;
`ifdef MIPS_WB_FWD_EN
   assign rd_ptr  = rd_ptr_q;
`endif

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write port arbiter: pipeline writeback has priority, MDU
// results queue in wb_fifo and retire in free slots. Reports pending-write
// hazards and requests a bubble when the queue starves or fills.
// Optional macro MIPS_WB_FWD_EN adds fwd_hit/fwd_data forwarding outputs.
module wb_write_arbiter
   import mips_pkg::*;
#(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   alu_vld,
   input  logic [REG_W-1:0]       alu_reg,
   input  logic [DATA_W-1:0]      alu_data,
   input  logic                   mdu_vld,
   output logic                   mdu_ready,
   input  logic [REG_W-1:0]       mdu_reg,
   input  logic [DATA_W-1:0]      mdu_data,
   output logic                   reg_wr,
   output logic [REG_W-1:0]       wr_reg,
   output logic [DATA_W-1:0]      wr_data,
   input  logic [REG_W-1:0]       chk_reg,
   output logic                   chk_busy,
   output logic                   stall_req,
   output logic [$clog2(DEPTH):0] fifo_cnt
`ifdef MIPS_WB_FWD_EN
   ,
   output logic                   fwd_hit,
   output logic [DATA_W-1:0]      fwd_data
`endif
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned SW = $clog2(STARVE_MAX + 1);

   logic                     slot_used, pop, push;
   wb_entry_t                head;
   logic [CW-1:0]            cnt;
   logic [DEPTH-1:0]         ent_vld;
   logic [DEPTH-1:0][REG_W-1:0] ent_reg;
`ifdef MIPS_WB_FWD_EN
   logic [DEPTH-1:0][DATA_W-1:0] ent_data;
   logic [CW-2:0]            rd_ptr;
`endif

   logic                     reg_wr_q, reg_wr_d;
   logic [REG_W-1:0]         wr_reg_q, wr_reg_d;
   logic [DATA_W-1:0]        wr_data_q, wr_data_d;
   logic [SW-1:0]            starve_q, starve_d;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .push_ent ('{wreg: mdu_reg, data: mdu_data}),
      .pop      (pop),
      .head     (head),
      .cnt      (cnt),
      .ent_vld  (ent_vld),
      .ent_reg  (ent_reg)
`ifdef MIPS_WB_FWD_EN
      ,
      .ent_data (ent_data),
      .rd_ptr   (rd_ptr)
`endif
   );

   assign mdu_ready = (cnt < CW'(DEPTH));

   // Slot arbitration, write-port selection and starve counter next state.
   always_comb begin
      slot_used = alu_vld && (alu_reg != REG_ZERO);
      pop       = !slot_used && (cnt != '0);
      push      = mdu_vld && mdu_ready && (mdu_reg != REG_ZERO);
      reg_wr_d  = slot_used || pop;
      wr_reg_d  = wr_reg_q;
      wr_data_d = wr_data_q;
      if (slot_used) begin
         wr_reg_d  = alu_reg;
         wr_data_d = alu_data;
      end else if (pop) begin
         wr_reg_d  = head.wreg;
         wr_data_d = head.data;
      end
      starve_d = starve_q;
      if (pop || (cnt == '0)) starve_d = '0;
      else if (starve_q != SW'(STARVE_MAX)) starve_d = starve_q + 1'b1;
   end

   // Registered write port and starve counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_wr_q  <= 1'b0;
         wr_reg_q  <= '0;
         wr_data_q <= '0;
         starve_q  <= '0;
      end else begin
         reg_wr_q  <= reg_wr_d;
         wr_reg_q  <= wr_reg_d;
         wr_data_q <= wr_data_d;
         starve_q  <= starve_d;
      end
   end

   // Hazard CAM over valid entries; an entry popping this cycle still matches.
   always_comb begin
      chk_busy = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (ent_vld[i] && (ent_reg[i] == chk_reg) && (chk_reg != REG_ZERO))
            chk_busy = 1'b1;
      end
   end

`ifdef MIPS_WB_FWD_EN
   // Forwarding: walk oldest to newest so the newest FIFO match wins, then
   // let a matching pipeline result (always younger) override it.
   always_comb begin
      logic [CW-2:0] idx;
      fwd_hit  = 1'b0;
      fwd_data = '0;
      idx      = '0;
      if (chk_reg != REG_ZERO) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + (CW-1)'(k);
            if ((k < 32'(cnt)) && (ent_reg[idx] == chk_reg)) begin
               fwd_hit  = 1'b1;
               fwd_data = ent_data[idx];
            end
         end
         if (slot_used && (alu_reg == chk_reg)) begin
            fwd_hit  = 1'b1;
            fwd_data = alu_data;
         end
      end
   end
`endif

   // Stall is decoded purely from registered state, so it drops the cycle
   // after the pop that clears the starve counter or relieves a full FIFO.
   assign stall_req = (starve_q == SW'(STARVE_MAX)) || (cnt == CW'(DEPTH));
   assign reg_wr    = reg_wr_q;
   assign wr_reg    = wr_reg_q;
   assign wr_data   = wr_data_q;
   assign fifo_cnt  = cnt;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed self-checking bench for wb_write_arbiter (DEPTH=4, STARVE_MAX=8).
module tb_wb_write_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_vld;
   logic [4:0]  alu_reg;
   logic [31:0] alu_data;
   logic        mdu_vld;
   logic        mdu_ready;
   logic [4:0]  mdu_reg;
   logic [31:0] mdu_data;
   logic        reg_wr;
   logic [4:0]  wr_reg;
   logic [31:0] wr_data;
   logic [4:0]  chk_reg;
   logic        chk_busy;
   logic        stall_req;
   logic [2:0]  fifo_cnt;
`ifdef MIPS_WB_FWD_EN
   logic        fwd_hit;
   logic [31:0] fwd_data;
`endif

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   wb_write_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .alu_vld   (alu_vld),
      .alu_reg   (alu_reg),
      .alu_data  (alu_data),
      .mdu_vld   (mdu_vld),
      .mdu_ready (mdu_ready),
      .mdu_reg   (mdu_reg),
      .mdu_data  (mdu_data),
      .reg_wr    (reg_wr),
      .wr_reg    (wr_reg),
      .wr_data   (wr_data),
      .chk_reg   (chk_reg),
      .chk_busy  (chk_busy),
      .stall_req (stall_req),
      .fifo_cnt  (fifo_cnt)
`ifdef MIPS_WB_FWD_EN
      ,
      .fwd_hit   (fwd_hit),
      .fwd_data  (fwd_data)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_wr(input string tag, input logic we, input logic [4:0] r, input logic [31:0] d);
      check({tag, ".reg_wr"}, 32'(reg_wr), 32'(we));
      if (we) begin
         check({tag, ".wr_reg"}, 32'(wr_reg), 32'(r));
         check({tag, ".wr_data"}, wr_data, d);
      end
   endtask

   initial begin
      rst_n = 1'b0; alu_vld = 0; alu_reg = 0; alu_data = 0;
      mdu_vld = 0; mdu_reg = 0; mdu_data = 0; chk_reg = 0;
      #3;
      check("rst.reg_wr",    32'(reg_wr), 0);
      check("rst.wr_reg",    32'(wr_reg), 0);
      check("rst.wr_data",   wr_data, 0);
      check("rst.fifo_cnt",  32'(fifo_cnt), 0);
      check("rst.stall",     32'(stall_req), 0);
      check("rst.mdu_ready", 32'(mdu_ready), 1);
      #9 rst_n = 1'b1;
      tick();

      // Single pipeline write, one-cycle latency
      alu_vld = 1; alu_reg = 5; alu_data = 32'h1234;
      tick();
      check_wr("alu1", 1, 5, 32'h1234);
      alu_vld = 0;
      tick();
      check_wr("alu1.idle", 0, 0, 0);

      // Starvation: pipeline busy on r3 while one MDU result waits
      alu_vld = 1; alu_reg = 3; alu_data = 32'h33;
      mdu_vld = 1; mdu_reg = 7; mdu_data = 32'hA5; chk_reg = 7;
      tick();
      mdu_vld = 0;
      check("starve.cnt", 32'(fifo_cnt), 1);
      check("starve.busy", 32'(chk_busy), 1);
      check_wr("starve.alu", 1, 3, 32'h33);
      for (int i = 0; i < 7; i++) tick();
      check("starve.stall7", 32'(stall_req), 0);
      tick();
      check("starve.stall8", 32'(stall_req), 1);
      chk_reg = 3; #1;
      check("starve.busy_r3", 32'(chk_busy), 0);
      chk_reg = 7; alu_vld = 0; #1;
      check("starve.busy_popping", 32'(chk_busy), 1);
      tick();
      check_wr("starve.drain", 1, 7, 32'hA5);
      check("starve.stall_off", 32'(stall_req), 0);
      check("starve.busy_off", 32'(chk_busy), 0);
      check("starve.cnt0", 32'(fifo_cnt), 0);

      // Fill to DEPTH with pipeline busy, reject a fifth result, drain in order
      alu_vld = 1; alu_reg = 3; mdu_vld = 1;
      for (int i = 0; i < 4; i++) begin
         mdu_reg = 5'(8 + i); mdu_data = 32'h100 + 32'(i);
         tick();
      end
      check("full.cnt", 32'(fifo_cnt), 4);
      check("full.ready", 32'(mdu_ready), 0);
      check("full.stall", 32'(stall_req), 1);
      mdu_reg = 12; mdu_data = 32'h1FF;
      tick();
      mdu_vld = 0; chk_reg = 12; #1;
      check("full.cnt_hold", 32'(fifo_cnt), 4);
      check("full.busy12", 32'(chk_busy), 0);
      alu_vld = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_wr($sformatf("drain%0d", i), 1, 5'(8 + i), 32'h100 + 32'(i));
         if (i == 0) check("drain.stall_off", 32'(stall_req), 0);
      end
      check("drain.cnt0", 32'(fifo_cnt), 0);
      tick();
      check_wr("drain.idle", 0, 0, 0);

      // Writes to r0 from either source are dropped
      alu_vld = 1; alu_reg = 0; alu_data = 32'hDEAD;
      mdu_vld = 1; mdu_reg = 0; mdu_data = 32'hFF; chk_reg = 0; #1;
      check("r0.ready", 32'(mdu_ready), 1);
      check("r0.busy", 32'(chk_busy), 0);
      tick();
      check_wr("r0.a", 0, 0, 0);
      check("r0.cnt", 32'(fifo_cnt), 0);
      alu_vld = 0; mdu_vld = 0;
      tick();
      check_wr("r0.b", 0, 0, 0);

      // Fill to 2, then simultaneous push/pop across pointer wrap
      alu_vld = 1; alu_reg = 3; alu_data = 32'h33; mdu_vld = 1;
      mdu_reg = 20; mdu_data = 32'h200; tick();
      mdu_reg = 21; mdu_data = 32'h201; tick();
      check("pp.cnt2", 32'(fifo_cnt), 2);
      alu_vld = 0;
      for (int i = 0; i < 4; i++) begin
         mdu_reg = 5'(22 + i); mdu_data = 32'h202 + 32'(i);
         tick();
         check_wr($sformatf("pp%0d", i), 1, 5'(20 + i), 32'h200 + 32'(i));
         check($sformatf("pp%0d.cnt", i), 32'(fifo_cnt), 2);
      end
      mdu_vld = 0;
      tick(); check_wr("pp.tail0", 1, 24, 32'h204);
      tick(); check_wr("pp.tail1", 1, 25, 32'h205);
      check("pp.cnt0", 32'(fifo_cnt), 0);

      // Asynchronous reset with three pending entries
      alu_vld = 1; alu_reg = 3; alu_data = 32'h33; mdu_vld = 1;
      for (int i = 0; i < 3; i++) begin
         mdu_reg = 5'(13 + i); mdu_data = 32'h300 + 32'(i);
         tick();
      end
      mdu_vld = 0; chk_reg = 13;
      check("ar.cnt3", 32'(fifo_cnt), 3);
      #2 rst_n = 1'b0; #1;
      check("ar.reg_wr",  32'(reg_wr), 0);
      check("ar.wr_reg",  32'(wr_reg), 0);
      check("ar.wr_data", wr_data, 0);
      check("ar.cnt",     32'(fifo_cnt), 0);
      check("ar.ready",   32'(mdu_ready), 1);
      check("ar.stall",   32'(stall_req), 0);
      check("ar.busy",    32'(chk_busy), 0);
      alu_vld = 0;
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_wr($sformatf("ar.post%0d", i), 0, 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
